sim_halt_monitor: RTL

//   Parametrised run-termination monitor for the mp4 bench; generalises the top-level halting logic.

---
 rtl/sim_halt_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sim_halt_monitor.sv
// Run-termination monitor: watches commit channels for halt, error, timeout and commit stall,
// then raises a sticky done with the winning cause plus saturating cycle/commit counters.
module sim_halt_monitor #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int STALL_CYCLES   = 10000,
  parameter int DRAIN_CYCLES   = 5,
  parameter int ERR_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       commit,
  input  logic [NUM_CH-1:0]       halt,
  input  logic [NUM_CH*ERR_W-1:0] errcode,
  output logic                    done,
  output logic [2:0]              cause,
  output logic [2:0]              err_ch,
  output logic [ERR_W-1:0]        err_val,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        commit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] C_HALT    = 3'd1;
  localparam logic [2:0] C_TIMEOUT = 3'd2;
  localparam logic [2:0] C_STALL   = 3'd3;
  localparam logic [2:0] C_ERROR   = 3'd4;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] STALL_LAST = (STALL_CYCLES > 0) ? CNT_W'(STALL_CYCLES - 1) : '0;
  localparam logic [DW-1:0]    DR_LAST    = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

  state_t             state_q;
  logic               done_q;
  logic [2:0]         cause_q;
  logic [2:0]         err_ch_q;
  logic [ERR_W-1:0]   err_val_q;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   commit_q;
  logic [CNT_W-1:0]   stall_q;
  logic [DW-1:0]      drain_q;

  logic               any_err;
  logic               any_halt;
  logic               any_commit;
  logic               timeout_hit;
  logic               stall_hit;
  logic               cnt_en;
  logic [2:0]         err_idx;
  logic [ERR_W-1:0]   err_sel;
  logic [3:0]         n_commit;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    any_err    = 1'b0;
    err_idx    = '0;
    err_sel    = '0;
    n_commit   = '0;
    any_halt   = |(commit & halt);
    any_commit = |commit;
    // Scan downward so the lowest-index erroring channel is the one left selected.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (errcode[i*ERR_W +: ERR_W] != '0) begin
        any_err = 1'b1;
        err_idx = 3'(i);
        err_sel = errcode[i*ERR_W +: ERR_W];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_commit = n_commit + 4'(commit[i]);
    end
    timeout_hit = (TIMEOUT_CYCLES > 0) && (cycle_q == TO_LAST);
    stall_hit   = (STALL_CYCLES > 0) && !any_commit && (stall_q == STALL_LAST);
    cnt_en      = ((state_q == S_RUN) && enable) || (state_q == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      cause_q   <= '0;
      err_ch_q  <= '0;
      err_val_q <= '0;
      cycle_q   <= '0;
      commit_q  <= '0;
      stall_q   <= '0;
      drain_q   <= '0;
    end else begin
      if (cnt_en) begin
        cycle_q  <= sat_add(cycle_q, 4'd1);
        commit_q <= sat_add(commit_q, n_commit);
      end
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= S_RUN;
        end
        S_RUN: begin
          if (enable) begin
            if (any_commit)           stall_q <= '0;
            else if (stall_q != '1)   stall_q <= stall_q + CNT_W'(1);
            // Priority: error > halt > stall > timeout; only the winner is recorded.
            if (any_err) begin
              cause_q   <= C_ERROR;
              err_ch_q  <= err_idx;
              err_val_q <= err_sel;
              drain_q   <= '0;
              if (DRAIN_CYCLES == 0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_DRAIN;
              end
            end else if (any_halt) begin
              cause_q <= C_HALT;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (stall_hit) begin
              cause_q <= C_STALL;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (timeout_hit) begin
              cause_q <= C_TIMEOUT;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == DR_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = done_q;
  assign cause      = cause_q;
  assign err_ch     = err_ch_q;
  assign err_val    = err_val_q;
  assign cycle_cnt  = cycle_q;
  assign commit_cnt = commit_q;

endmodule
